// File: rtl/leon_cache_stub_if.sv
`default_nettype none
// ============================================================================
// Module   : leon_cache_stub_if
// Purpose  : Bus bundle between the integer-unit core side and the cache stub.
// Revision : 1.0
// ============================================================================
interface leon_cache_stub_if #(
  parameter int DW = 32
);
  logic          inst_wr;
  logic [DW-1:0] inst_wdata;
  logic          inst_full;
  logic          ld_wr;
  logic [DW-1:0] ld_wdata;
  logic          ld_full;
  logic [3:0]    wait_cfg;
  logic          ic_req;
  logic [DW-1:0] ic_data;
  logic          ic_hold;
  logic          dc_req;
  logic          dc_write;
  logic [DW-1:0] dc_wdata;
  logic [DW-1:0] dc_data;
  logic          dc_hold;
  logic          st_valid;
  logic [DW-1:0] st_data;
  logic [1:0]    ovf;
  logic [1:0]    udf;

  modport slave (
    input  inst_wr, inst_wdata, ld_wr, ld_wdata, wait_cfg,
           ic_req, dc_req, dc_write, dc_wdata,
    output inst_full, ld_full, ic_data, ic_hold, dc_data, dc_hold,
           st_valid, st_data, ovf, udf
  );

  modport master (
    output inst_wr, inst_wdata, ld_wr, ld_wdata, wait_cfg,
           ic_req, dc_req, dc_write, dc_wdata,
    input  inst_full, ld_full, ic_data, ic_hold, dc_data, dc_hold,
           st_valid, st_data, ovf, udf
  );
endinterface
`default_nettype wire

// File: rtl/leon_cache_stub.sv
`default_nettype none
// ============================================================================
// Module   : leon_cache_stub
// Purpose  : Queued IC/DC responder with programmable hold cycles and store capture.
// Revision : 1.0
// ============================================================================
module leon_cache_stub #(
  parameter int            DW       = 32,
  parameter int            DEPTH    = 8,
  parameter logic [DW-1:0] NOP_WORD = DW'(32'h0100_0000)
) (
  input  logic             clk,
  input  logic             rst,
  leon_cache_stub_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Index 0 is the instruction FIFO (IC channel), index 1 the load FIFO (DC).
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    full;
  logic [1:0]    empty;
  logic [1:0]    ovf_bit;
  logic [1:0]    udf_bit;
  logic [DW-1:0] push_data [2];
  logic [DW-1:0] head      [2];

  state_t        ic_state;
  state_t        ic_state_nxt;
  logic [3:0]    ic_cnt;
  logic [3:0]    ic_cnt_nxt;
  logic          ic_enter;
  logic          ic_hold;

  state_t        dc_state;
  state_t        dc_state_nxt;
  logic [3:0]    dc_cnt;
  logic [3:0]    dc_cnt_nxt;
  logic          dc_enter;
  logic          dc_hold;
  logic          dc_accept;
  logic          dc_write_q;
  logic [DW-1:0] dc_wdata_q;
  logic          dc_store;
  logic [DW-1:0] dc_store_word;

  logic [DW-1:0] ic_data_q;
  logic [DW-1:0] dc_data_q;
  logic          st_valid_q;
  logic [DW-1:0] st_data_q;

  assign push         = {bus.ld_wr, bus.inst_wr};
  assign push_data[0] = bus.inst_wdata;
  assign push_data[1] = bus.ld_wdata;
  assign pop          = {dc_enter & ~dc_store, ic_enter};

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          do_push;
    logic          do_pop;
    logic          ovf_r;
    logic          udf_r;

    assign empty[g]   = (wptr == rptr);
    assign full[g]    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign do_pop     = pop[g] && !empty[g];
    assign do_push    = push[g] && (!full[g] || pop[g]);
    assign head[g]    = mem[rptr[AW-1:0]];
    assign ovf_bit[g] = ovf_r;
    assign udf_bit[g] = udf_r;

    always_ff @(posedge clk) begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= push_data[g];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wptr  <= '0;
        rptr  <= '0;
        ovf_r <= 1'b0;
        udf_r <= 1'b0;
      end else begin
        if (do_push) begin
          wptr <= wptr + 1'b1;
        end
        if (do_pop) begin
          rptr <= rptr + 1'b1;
        end
        if (push[g] && full[g] && !pop[g]) begin
          ovf_r <= 1'b1;
        end
        if (pop[g] && empty[g]) begin
          udf_r <= 1'b1;
        end
      end
    end
  end

  // ---------------- IC channel ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ic_state <= S_IDLE;
      ic_cnt   <= '0;
    end else begin
      ic_state <= ic_state_nxt;
      ic_cnt   <= ic_cnt_nxt;
    end
  end

  // ic_enter marks the edge that moves into RESP; the pop happens there so the
  // registered word is on ic_data throughout the RESP cycle.
  always_comb begin
    ic_state_nxt = ic_state;
    ic_cnt_nxt   = ic_cnt;
    ic_enter     = 1'b0;
    ic_hold      = 1'b1;
    case (ic_state)
      S_IDLE: begin
        if (bus.ic_req) begin
          ic_cnt_nxt = bus.wait_cfg;
          if (bus.wait_cfg == 4'd0) begin
            ic_state_nxt = S_RESP;
            ic_enter     = 1'b1;
          end else begin
            ic_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        ic_hold    = 1'b0;
        ic_cnt_nxt = ic_cnt - 4'd1;
        if (ic_cnt == 4'd1) begin
          ic_state_nxt = S_RESP;
          ic_enter     = 1'b1;
        end
      end
      S_RESP: begin
        ic_state_nxt = S_IDLE;
      end
      default: begin
        ic_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------- DC channel ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dc_state   <= S_IDLE;
      dc_cnt     <= '0;
      dc_write_q <= 1'b0;
      dc_wdata_q <= '0;
    end else begin
      dc_state <= dc_state_nxt;
      dc_cnt   <= dc_cnt_nxt;
      if (dc_accept) begin
        dc_write_q <= bus.dc_write;
        dc_wdata_q <= bus.dc_wdata;
      end
    end
  end

  always_comb begin
    dc_state_nxt = dc_state;
    dc_cnt_nxt   = dc_cnt;
    dc_enter     = 1'b0;
    dc_hold      = 1'b1;
    dc_accept    = 1'b0;
    case (dc_state)
      S_IDLE: begin
        if (bus.dc_req) begin
          dc_accept  = 1'b1;
          dc_cnt_nxt = bus.wait_cfg;
          if (bus.wait_cfg == 4'd0) begin
            dc_state_nxt = S_RESP;
            dc_enter     = 1'b1;
          end else begin
            dc_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        dc_hold    = 1'b0;
        dc_cnt_nxt = dc_cnt - 4'd1;
        if (dc_cnt == 4'd1) begin
          dc_state_nxt = S_RESP;
          dc_enter     = 1'b1;
        end
      end
      S_RESP: begin
        dc_state_nxt = S_IDLE;
      end
      default: begin
        dc_state_nxt = S_IDLE;
      end
    endcase
  end

  // A zero-wait access enters RESP on the accepting edge, before the latch is loaded.
  assign dc_store      = (dc_state == S_IDLE) ? bus.dc_write : dc_write_q;
  assign dc_store_word = (dc_state == S_IDLE) ? bus.dc_wdata : dc_wdata_q;

  // ---------------- Response registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ic_data_q  <= NOP_WORD;
      dc_data_q  <= '0;
      st_valid_q <= 1'b0;
      st_data_q  <= '0;
    end else begin
      st_valid_q <= dc_enter && dc_store;
      if (ic_enter) begin
        ic_data_q <= empty[0] ? NOP_WORD : head[0];
      end
      if (dc_enter && !dc_store) begin
        dc_data_q <= empty[1] ? '0 : head[1];
      end
      if (dc_enter && dc_store) begin
        st_data_q <= dc_store_word;
      end
    end
  end

  assign bus.inst_full = full[0];
  assign bus.ld_full   = full[1];
  assign bus.ic_data   = ic_data_q;
  assign bus.ic_hold   = ic_hold;
  assign bus.dc_data   = dc_data_q;
  assign bus.dc_hold   = dc_hold;
  assign bus.st_valid  = st_valid_q;
  assign bus.st_data   = st_data_q;
  assign bus.ovf       = ovf_bit;
  assign bus.udf       = udf_bit;

endmodule
`default_nettype wire

// File: tb/tb_leon_cache_stub.sv
`default_nettype none
// ============================================================================
// Module   : tb_leon_cache_stub
// Purpose  : Directed bench for leon_cache_stub with a timestamp/queue model.
// Revision : 1.0
// ============================================================================
module tb_leon_cache_stub;

  localparam int          DW    = 32;
  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h0100_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  leon_cache_stub_if #(.DW(DW)) bus ();

  leon_cache_stub #(
    .DW      (DW),
    .DEPTH   (DEPTH),
    .NOP_WORD(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: queues for the FIFOs; each access is tracked by its accept edge and
  // the cycle index of its response. Cycle k is the cycle following edge k-1.
  logic [31:0] inst_q[$];
  logic [31:0] ld_q[$];
  int          edge_n  = 0;
  int          e;
  int          ic_acc  = -100, ic_rc = -100, ic_free = 0;
  int          dc_acc  = -100, dc_rc = -100, dc_free = 0;
  bit          dc_st   = 1'b0;
  logic [31:0] dc_sw   = '0;

  logic        exp_ic_hold   = 1'b1;
  logic        exp_dc_hold   = 1'b1;
  logic        exp_st_valid  = 1'b0;
  logic        exp_inst_full = 1'b0;
  logic        exp_ld_full   = 1'b0;
  logic [31:0] exp_ic_data   = NOP;
  logic [31:0] exp_dc_data   = '0;
  logic [31:0] exp_st_data   = '0;
  logic [1:0]  exp_ovf       = '0;
  logic [1:0]  exp_udf       = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q.delete();
      ld_q.delete();
      ic_acc = -100; ic_rc = -100; ic_free = 0;
      dc_acc = -100; dc_rc = -100; dc_free = 0;
      exp_ic_hold = 1'b1;  exp_dc_hold = 1'b1;
      exp_st_valid = 1'b0; exp_inst_full = 1'b0; exp_ld_full = 1'b0;
      exp_ic_data = NOP;   exp_dc_data = '0; exp_st_data = '0;
      exp_ovf = '0;        exp_udf = '0;
    end else begin
      edge_n++;
      e = edge_n;
      if (e >= ic_free && bus.ic_req) begin
        ic_acc  = e;
        ic_rc   = e + 1 + int'(bus.wait_cfg);
        ic_free = ic_rc + 1;
      end
      if (e >= dc_free && bus.dc_req) begin
        dc_acc  = e;
        dc_rc   = e + 1 + int'(bus.wait_cfg);
        dc_free = dc_rc + 1;
        dc_st   = bus.dc_write;
        dc_sw   = bus.dc_wdata;
      end
      exp_st_valid = 1'b0;
      if (ic_rc == e + 1) begin
        if (inst_q.size() == 0) begin
          exp_ic_data = NOP;
          exp_udf[0]  = 1'b1;
        end else begin
          exp_ic_data = inst_q.pop_front();
        end
      end
      if (dc_rc == e + 1) begin
        if (dc_st) begin
          exp_st_valid = 1'b1;
          exp_st_data  = dc_sw;
        end else if (ld_q.size() == 0) begin
          exp_dc_data = '0;
          exp_udf[1]  = 1'b1;
        end else begin
          exp_dc_data = ld_q.pop_front();
        end
      end
      // Pushes after pops: a slot freed this edge is reusable by the same edge's push.
      if (bus.inst_wr) begin
        if (inst_q.size() < DEPTH) inst_q.push_back(bus.inst_wdata);
        else exp_ovf[0] = 1'b1;
      end
      if (bus.ld_wr) begin
        if (ld_q.size() < DEPTH) ld_q.push_back(bus.ld_wdata);
        else exp_ovf[1] = 1'b1;
      end
      exp_inst_full = (inst_q.size() == DEPTH);
      exp_ld_full   = (ld_q.size() == DEPTH);
      exp_ic_hold   = !((ic_acc < e + 1) && (e + 1 < ic_rc));
      exp_dc_hold   = !((dc_acc < e + 1) && (e + 1 < dc_rc));
    end
  end

  always @(negedge clk) begin
    expect_eq("cyc_ic_hold",   32'(bus.ic_hold),   32'(exp_ic_hold));
    expect_eq("cyc_dc_hold",   32'(bus.dc_hold),   32'(exp_dc_hold));
    expect_eq("cyc_ic_data",   bus.ic_data,        exp_ic_data);
    expect_eq("cyc_dc_data",   bus.dc_data,        exp_dc_data);
    expect_eq("cyc_st_valid",  32'(bus.st_valid),  32'(exp_st_valid));
    expect_eq("cyc_st_data",   bus.st_data,        exp_st_data);
    expect_eq("cyc_inst_full", 32'(bus.inst_full), 32'(exp_inst_full));
    expect_eq("cyc_ld_full",   32'(bus.ld_full),   32'(exp_ld_full));
    expect_eq("cyc_ovf",       32'(bus.ovf),       32'(exp_ovf));
    expect_eq("cyc_udf",       32'(bus.udf),       32'(exp_udf));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] want;
    bus.inst_wr = 1'b0; bus.inst_wdata = '0;
    bus.ld_wr   = 1'b0; bus.ld_wdata   = '0;
    bus.wait_cfg = '0;
    bus.ic_req  = 1'b0; bus.dc_req = 1'b0; bus.dc_write = 1'b0; bus.dc_wdata = '0;

    repeat (2) @(negedge clk);
    expect_eq("rst_ic_hold", 32'(bus.ic_hold), 32'd1);
    expect_eq("rst_ic_data", bus.ic_data, 32'h0100_0000);
    expect_eq("rst_dc_data", bus.dc_data, 32'h0);
    expect_eq("rst_flags", 32'({bus.ovf, bus.udf}), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Two fetches at zero wait, request held high
    bus.inst_wr = 1'b1; bus.inst_wdata = 32'h8200_4003; @(negedge clk);
    bus.inst_wdata = 32'h0100_0000; @(negedge clk);
    bus.inst_wr = 1'b0; bus.wait_cfg = 4'd0; bus.ic_req = 1'b1; @(negedge clk);
    expect_eq("t1_word0", bus.ic_data, 32'h8200_4003);
    @(negedge clk);
    @(negedge clk);
    expect_eq("t1_word1", bus.ic_data, 32'h0100_0000);
    bus.ic_req = 1'b0;

    // Load with three stall cycles
    bus.ld_wr = 1'b1; bus.ld_wdata = 32'hDEAD_BEEF; @(negedge clk);
    bus.ld_wr = 1'b0; bus.wait_cfg = 4'd3; bus.dc_req = 1'b1; bus.dc_write = 1'b0; @(negedge clk);
    bus.dc_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_eq("t2_stall", 32'(bus.dc_hold), 32'd0);
      @(negedge clk);
    end
    expect_eq("t2_hold", 32'(bus.dc_hold), 32'd1);
    expect_eq("t2_data", bus.dc_data, 32'hDEAD_BEEF);
    @(negedge clk);

    // Store capture with one stall cycle
    bus.wait_cfg = 4'd1; bus.dc_req = 1'b1; bus.dc_write = 1'b1; bus.dc_wdata = 32'h1234_5678;
    @(negedge clk);
    bus.dc_req = 1'b0; bus.dc_write = 1'b0;
    expect_eq("t3_stall", 32'(bus.dc_hold), 32'd0);
    expect_eq("t3_no_pulse", 32'(bus.st_valid), 32'd0);
    @(negedge clk);
    expect_eq("t3_pulse", 32'(bus.st_valid), 32'd1);
    expect_eq("t3_st_data", bus.st_data, 32'h1234_5678);
    expect_eq("t3_dc_kept", bus.dc_data, 32'hDEAD_BEEF);
    @(negedge clk);
    expect_eq("t3_pulse_end", 32'(bus.st_valid), 32'd0);

    // Instruction underflow, then push and pop on the same edge while empty
    bus.wait_cfg = 4'd0; bus.ic_req = 1'b1; @(negedge clk);
    bus.ic_req = 1'b0;
    expect_eq("t4_nop", bus.ic_data, 32'h0100_0000);
    expect_eq("t4_udf", 32'(bus.udf), 32'd1);
    @(negedge clk);
    bus.ic_req = 1'b1; bus.inst_wr = 1'b1; bus.inst_wdata = 32'hA5A5_0001; @(negedge clk);
    bus.ic_req = 1'b0; bus.inst_wr = 1'b0;
    expect_eq("t4_same_edge", bus.ic_data, 32'h0100_0000);
    @(negedge clk);
    bus.ic_req = 1'b1; @(negedge clk);
    bus.ic_req = 1'b0;
    expect_eq("t4_stored", bus.ic_data, 32'hA5A5_0001);
    @(negedge clk);

    // Fill the load FIFO, then push and pop together while full
    for (int i = 0; i < DEPTH; i++) begin
      bus.ld_wr = 1'b1; bus.ld_wdata = 32'h200 + 32'(i); @(negedge clk);
    end
    expect_eq("t5_ld_full", 32'(bus.ld_full), 32'd1);
    bus.ld_wdata = 32'h2FF; bus.dc_req = 1'b1; bus.dc_write = 1'b0; bus.wait_cfg = 4'd0;
    @(negedge clk);
    bus.ld_wr = 1'b0; bus.dc_req = 1'b0;
    expect_eq("t5_ld_head", bus.dc_data, 32'h200);
    expect_eq("t5_still_full", 32'(bus.ld_full), 32'd1);
    expect_eq("t5_no_ovf", 32'(bus.ovf), 32'd0);

    // Overfill the instruction FIFO by one, then drain it
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.inst_wr = 1'b1; bus.inst_wdata = 32'h100 + 32'(i); @(negedge clk);
    end
    bus.inst_wr = 1'b0;
    expect_eq("t5_inst_full", 32'(bus.inst_full), 32'd1);
    expect_eq("t5_ovf", 32'(bus.ovf), 32'd1);
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.ic_req = 1'b1; @(negedge clk);
      bus.ic_req = 1'b0;
      want = (i < DEPTH) ? 32'h100 + 32'(i) : NOP;
      expect_eq("t5_drain", bus.ic_data, want);
      @(negedge clk);
    end

    // Reset in the middle of a long stall
    bus.wait_cfg = 4'd7; bus.dc_req = 1'b1; @(negedge clk);
    bus.dc_req = 1'b0; @(negedge clk);
    expect_eq("t6_stall", 32'(bus.dc_hold), 32'd0);
    expect_eq("t6_full_before", 32'(bus.ld_full), 32'd1);
    #2 rst = 1'b0;
    #1;
    expect_eq("t6_async_hold", 32'(bus.dc_hold), 32'd1);
    expect_eq("t6_async_full", 32'(bus.ld_full), 32'd0);
    expect_eq("t6_async_flags", 32'({bus.ovf, bus.udf}), 32'h0);
    expect_eq("t6_async_ic", bus.ic_data, 32'h0100_0000);
    expect_eq("t6_async_dc", bus.dc_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.ld_wr = 1'b1; bus.ld_wdata = 32'hCAFE_F00D; @(negedge clk);
    bus.ld_wr = 1'b0; bus.dc_req = 1'b1; bus.dc_write = 1'b0; bus.wait_cfg = 4'd2; @(negedge clk);
    bus.dc_req = 1'b0;
    expect_eq("t6_post_stall0", 32'(bus.dc_hold), 32'd0);
    @(negedge clk);
    expect_eq("t6_post_stall1", 32'(bus.dc_hold), 32'd0);
    @(negedge clk);
    expect_eq("t6_post_hold", 32'(bus.dc_hold), 32'd1);
    expect_eq("t6_post_data", bus.dc_data, 32'hCAFE_F00D);
    expect_eq("t6_post_udf", 32'(bus.udf), 32'd0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
